som_train_ctrl: RTL and testbench
=================================

SOM_TRAIN_CTRL -- requirements
Module: som_train_ctrl

Interface
REQ-001 SHALL have parameter N_NEURON, default 16: number of neurons on the distance bus (2..16).
REQ-002 SHALL have parameter PIX_PER_EPOCH, default 64: pixels per epoch.
REQ-003 SHALL have parameter NUM_EPOCH, default 8: epochs per training run.
REQ-004 SHALL have parameter EPOCH_STEP, default 2: epochs between learning-rate shift increments.
REQ-005 SHALL have parameters U0_INIT/U1_INIT/U2_INIT, defaults 1/2/3: initial shift values.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: begin training run; sampled only in IDLE.
REQ-009 SHALL have port pix_valid, input, 1: pixel_in valid.
REQ-010 SHALL have port pixel_in, input, 24: {R,G,B} sample.
REQ-011 SHALL have port pix_ready, output, 1: controller accepts pixel.
REQ-012 SHALL have port dist_bus, input, 18*N_NEURON: neuron i total_dist at bits [18i+17:18i].
REQ-013 SHALL have port pixel, output, 24: registered pixel broadcast to all neurons.
REQ-014 SHALL have ports S_wr, op_wr, USS_ctrl, output, 1 each: neuron strobes.
REQ-015 SHALL have port coordinate_c, output, 4: winner coordinate broadcast.
REQ-016 SHALL have ports U0, U1, U2, output, 4 each: neighbourhood shift values.
REQ-017 SHALL have ports busy, output, 1; done, output, 1; epoch, output, 8; winner, output, 4.

Function
REQ-018 SHALL implement states IDLE, LOAD, SETTLE, SCAN, SHIFT, UPDATE, NEXT.
REQ-019 IDLE: start=1 -> LOAD; pixel/epoch counters cleared; U0..U2 loaded with *_INIT values.
REQ-020 LOAD: pix_ready=1; on pix_valid=1 pixel<=pixel_in and -> SETTLE; else hold.
REQ-021 pix_ready SHALL be 1 only in LOAD; pix_valid outside LOAD is ignored.
REQ-022 SETTLE: exactly one cycle, no strobes, -> SCAN (neuron total_dist register settles).
REQ-023 SCAN: index 0..N_NEURON-1, one neuron per cycle; index 0 loads best unconditionally; later index replaces best only if its distance is strictly less (tie -> lowest index).
REQ-024 SCAN -> SHIFT after index N_NEURON-1 compared; winner<=best index.
REQ-025 SHIFT: one cycle, S_wr=1, USS_ctrl=1, coordinate_c=winner; -> UPDATE.
REQ-026 UPDATE: one cycle, op_wr=1, coordinate_c held; -> NEXT.
REQ-027 NEXT: pixel counter +1; at PIX_PER_EPOCH-1 wraps to 0 and epoch +1.
REQ-028 NEXT: if last pixel of epoch NUM_EPOCH-1 -> done=1 for exactly one cycle (the NEXT->IDLE transition cycle), -> IDLE; else -> LOAD.
REQ-029 On each epoch completion, step counter +1; at EPOCH_STEP-1 it clears and U0,U1,U2 each +1, saturating at 15.
REQ-030 S_wr, op_wr, USS_ctrl SHALL never be asserted together and SHALL be 0 outside SHIFT/UPDATE.
REQ-031 Per-pixel throughput: pix_ready reasserted N_NEURON+4 cycles after the accepting edge (20 for defaults).
REQ-032 busy=1 in every state except IDLE; start while busy is ignored.
REQ-033 Distance compare SHALL be unsigned 18-bit; 18'h3FFFF is a legal distance.
REQ-034 coordinate_c, winner SHALL retain last value after UPDATE until next SHIFT.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE from any state, including mid-SCAN or UPDATE.
REQ-036 Reset values: pixel=0, pix_ready=0, S_wr=0, op_wr=0, USS_ctrl=0, coordinate_c=0, winner=0, U0/U1/U2=*_INIT, busy=0, done=0, epoch=0, all counters 0.

Verification
REQ-037 Single pixel, N=16, dist[i]=100+i except dist[9]=5 -> winner=9, SHIFT with coordinate_c=9, op_wr one cycle later, pix_ready back 20 cycles after accept.
REQ-038 Tie: dist[3]=dist[11]=7, others 50 -> winner=3.
REQ-039 All distances 18'h3FFFF -> winner=0; no X on outputs.
REQ-040 PIX_PER_EPOCH=2, NUM_EPOCH=4, EPOCH_STEP=2 -> epoch steps 0..3, U0/U1/U2 become 2/3/4 after epoch 1, done pulses once after 8th pixel, then IDLE.
REQ-041 rst asserted mid-SCAN -> next cycle IDLE, all strobes 0, epoch=0; new start runs cleanly.
REQ-042 pix_valid held low in LOAD for 10 cycles -> no strobes, state held; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/som_train_ctrl.sv
// SOM training sequencer: accepts pixels, scans neuron distances for the
// best-matching unit, strobes the update, and anneals neighbourhood shifts.
module som_train_ctrl #(
  parameter int N_NEURON      = 16,
  parameter int PIX_PER_EPOCH = 64,
  parameter int NUM_EPOCH     = 8,
  parameter int EPOCH_STEP    = 2,
  parameter int U0_INIT       = 1,
  parameter int U1_INIT       = 2,
  parameter int U2_INIT       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    pix_valid,
  input  logic [23:0]             pixel_in,
  output logic                    pix_ready,
  input  logic [18*N_NEURON-1:0]  dist_bus,
  output logic [23:0]             pixel,
  output logic                    S_wr,
  output logic                    op_wr,
  output logic                    USS_ctrl,
  output logic [3:0]              coordinate_c,
  output logic [3:0]              U0,
  output logic [3:0]              U1,
  output logic [3:0]              U2,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              epoch,
  output logic [3:0]              winner
);

  localparam int PW = (PIX_PER_EPOCH > 1) ? $clog2(PIX_PER_EPOCH) : 1;
  localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_PER_EPOCH - 1);
  localparam logic [7:0]    EP_LAST   = 8'(NUM_EPOCH - 1);
  localparam logic [7:0]    STEP_LAST = 8'(EPOCH_STEP - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(N_NEURON - 1);
  localparam logic [3:0]    U0_RST    = 4'(U0_INIT);
  localparam logic [3:0]    U1_RST    = 4'(U1_INIT);
  localparam logic [3:0]    U2_RST    = 4'(U2_INIT);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, SCAN, SHIFT, UPDATE, NEXT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [17:0]     best_dist_q, best_dist_d;
  logic [3:0]      best_idx_q, best_idx_d;
  logic [3:0]      winner_q, winner_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [7:0]      epoch_q, epoch_d;
  logic [7:0]      step_q, step_d;
  logic [3:0]      u0_q, u0_d, u1_q, u1_d, u2_q, u2_d;
  logic [23:0]     pixel_q, pixel_d;

  // Unused slots read as max distance so a stray index can never win.
  logic [17:0] dist_a [16];
  for (genvar g = 0; g < 16; g++) begin : g_dist
    if (g < N_NEURON) begin : g_on
      assign dist_a[g] = dist_bus[18*g +: 18];
    end else begin : g_off
      assign dist_a[g] = '1;
    end
  end

  logic [17:0] dist_sel;
  logic        take;
  logic [17:0] cand_dist;
  logic [3:0]  cand_idx;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      winner_q    <= '0;
      pix_cnt_q   <= '0;
      epoch_q     <= '0;
      step_q      <= '0;
      u0_q        <= U0_RST;
      u1_q        <= U1_RST;
      u2_q        <= U2_RST;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      winner_q    <= winner_d;
      pix_cnt_q   <= pix_cnt_d;
      epoch_q     <= epoch_d;
      step_q      <= step_d;
      u0_q        <= u0_d;
      u1_q        <= u1_d;
      u2_q        <= u2_d;
      pixel_q     <= pixel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    winner_d    = winner_q;
    pix_cnt_d   = pix_cnt_q;
    epoch_d     = epoch_q;
    step_d      = step_q;
    u0_d        = u0_q;
    u1_d        = u1_q;
    u2_d        = u2_q;
    pixel_d     = pixel_q;
    done        = 1'b0;
    dist_sel    = dist_a[idx_q];
    // Strict less-than keeps the lowest index on ties.
    take        = (idx_q == 4'd0) || (dist_sel < best_dist_q);
    cand_dist   = take ? dist_sel : best_dist_q;
    cand_idx    = take ? idx_q : best_idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          pix_cnt_d = '0;
          epoch_d   = '0;
          step_d    = '0;
          u0_d      = U0_RST;
          u1_d      = U1_RST;
          u2_d      = U2_RST;
        end
      end
      LOAD: begin
        if (pix_valid) begin
          pixel_d = pixel_in;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        best_dist_d = cand_dist;
        best_idx_d  = cand_idx;
        if (idx_q == IDX_LAST) begin
          winner_d = cand_idx;
          state_d  = SHIFT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      SHIFT:  state_d = UPDATE;
      UPDATE: state_d = NEXT;
      NEXT: begin
        state_d = LOAD;
        if (pix_cnt_q == PIX_LAST) begin
          pix_cnt_d = '0;
          epoch_d   = epoch_q + 8'd1;
          if (step_q == STEP_LAST) begin
            step_d = '0;
            u0_d   = sat_inc(u0_q);
            u1_d   = sat_inc(u1_q);
            u2_d   = sat_inc(u2_q);
          end else begin
            step_d = step_q + 8'd1;
          end
          if (epoch_q == EP_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_ready    = (state_q == LOAD);
  assign S_wr         = (state_q == SHIFT);
  assign USS_ctrl     = (state_q == SHIFT);
  assign op_wr        = (state_q == UPDATE);
  assign busy         = (state_q != IDLE);
  assign pixel        = pixel_q;
  assign winner       = winner_q;
  assign coordinate_c = winner_q;
  assign epoch        = epoch_q;
  assign U0           = u0_q;
  assign U1           = u1_q;
  assign U2           = u2_q;

endmodule

// File: tb/tb_som_train_ctrl.sv
// Directed bench for som_train_ctrl: winner search, strobe timing, epoch
// annealing, done pulse, reset mid-scan and LOAD back-pressure.
module tb_som_train_ctrl;

  localparam int N = 16;

  logic            clk = 1'b0;
  logic            rst, start, pix_valid;
  logic [23:0]     pixel_in;
  logic [18*N-1:0] dist_bus;
  logic            pix_ready, S_wr, op_wr, USS_ctrl, busy, done;
  logic [23:0]     pixel;
  logic [3:0]      coordinate_c, U0, U1, U2, winner;
  logic [7:0]      epoch;

  int n_cmp = 0;
  int n_bad = 0;

  som_train_ctrl #(
    .N_NEURON(N), .PIX_PER_EPOCH(2), .NUM_EPOCH(4), .EPOCH_STEP(2),
    .U0_INIT(1), .U1_INIT(2), .U2_INIT(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
    .pixel_in(pixel_in), .pix_ready(pix_ready), .dist_bus(dist_bus),
    .pixel(pixel), .S_wr(S_wr), .op_wr(op_wr), .USS_ctrl(USS_ctrl),
    .coordinate_c(coordinate_c), .U0(U0), .U1(U1), .U2(U2),
    .busy(busy), .done(done), .epoch(epoch), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic dist_winner9();
    for (int i = 0; i < N; i++) dist_bus[18*i +: 18] = 18'(100 + i);
    dist_bus[18*9 +: 18] = 18'd5;
  endtask

  task automatic dist_tie();
    for (int i = 0; i < N; i++) dist_bus[18*i +: 18] = 18'd50;
    dist_bus[18*3 +: 18]  = 18'd7;
    dist_bus[18*11 +: 18] = 18'd7;
  endtask

  task automatic dist_max();
    for (int i = 0; i < N; i++) dist_bus[18*i +: 18] = 18'h3FFFF;
  endtask

  // Called at a negedge while in LOAD. Records the cycle (counted from the
  // accepting edge) of each strobe, done, and pix_ready/idle return.
  task automatic run_pixel(input logic [23:0] px, input logic [3:0] exp_w, input bit last);
    int sk, uk, rk, ik, dk, dn, ns, no, ovl;
    sk = -1; uk = -1; rk = -1; ik = -1; dk = -1; dn = 0; ns = 0; no = 0; ovl = 0;
    chk("rdy_before", pix_ready, 1);
    pixel_in  = px;
    pix_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      pix_valid = 1'b0;
      if (k == 0) chk("pixel_reg", pixel, px);
      if ((S_wr || USS_ctrl) && op_wr) ovl++;
      if (S_wr) begin
        ns++;
        if (sk < 0) begin
          sk = k;
          chk("coord_shift", coordinate_c, exp_w);
          chk("uss_shift", USS_ctrl, 1);
        end
      end
      if (op_wr) begin
        no++;
        if (uk < 0) begin
          uk = k;
          chk("coord_upd", coordinate_c, exp_w);
        end
      end
      if (done) begin
        dn++;
        if (dk < 0) dk = k;
      end
      if (pix_ready) begin rk = k; break; end
      if (!busy) begin ik = k; break; end
    end
    chk("winner", winner, exp_w);
    chk("shift_cyc", sk, N + 1);
    chk("upd_cyc", uk, N + 2);
    chk("strobe_cnt", {ns[15:0], no[15:0]}, {16'd1, 16'd1});
    chk("strobe_ovl", ovl, 0);
    if (last) begin
      chk("done_cnt", dn, 1);
      chk("done_cyc", dk, N + 3);
      chk("idle_cyc", ik, N + 4);
      chk("done_after", done, 0);
    end else begin
      chk("rdy_cyc", rk, N + 4);
      chk("no_done", dn, 0);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int bad_hold;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pixel_in = '0;
    dist_bus = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", pix_ready, 0);
    chk("rst_strobes", {S_wr, op_wr, USS_ctrl, done}, 0);
    chk("rst_pix", pixel, 0);
    chk("rst_win", {winner, coordinate_c}, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_u", {U0, U1, U2}, {4'd1, 4'd2, 4'd3});
    rst = 1'b0;

    // Full run: 4 epochs of 2 pixels.
    pulse_start();
    chk("run_busy", busy, 1);
    dist_winner9(); run_pixel(24'hABCDEF, 4'd9, 0);
    dist_tie();     run_pixel(24'h123456, 4'd3, 0);
    chk("ep1", epoch, 1);
    chk("u_ep1", {U0, U1, U2}, {4'd1, 4'd2, 4'd3});
    dist_max();     run_pixel(24'hFFFFFF, 4'd0, 0);
    chk("no_x", {31'b0, $isunknown({pixel, pix_ready, S_wr, op_wr, USS_ctrl,
                 coordinate_c, U0, U1, U2, busy, done, epoch, winner})}, 0);
    dist_winner9(); run_pixel(24'h000001, 4'd9, 0);
    chk("ep2", epoch, 2);
    chk("u_ep2", {U0, U1, U2}, {4'd2, 4'd3, 4'd4});

    // LOAD back-pressure with a stray start while busy.
    bad_hold = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      @(negedge clk);
      if (!pix_ready || S_wr || op_wr || USS_ctrl || !busy) bad_hold++;
    end
    start = 1'b0;
    chk("load_hold", bad_hold, 0);
    chk("hold_epoch", epoch, 2);
    dist_tie();     run_pixel(24'h0A0B0C, 4'd3, 0);
    dist_max();     run_pixel(24'h0D0E0F, 4'd0, 0);
    chk("ep3", epoch, 3);
    dist_winner9(); run_pixel(24'h111111, 4'd9, 0);
    dist_tie();     run_pixel(24'h222222, 4'd3, 1);
    chk("end_idle", {busy, pix_ready}, 0);

    // Restart reloads shifts and counters.
    pulse_start();
    chk("re_u", {U0, U1, U2}, {4'd1, 4'd2, 4'd3});
    chk("re_epoch", epoch, 0);
    dist_winner9(); run_pixel(24'h333333, 4'd9, 0);
    dist_tie();     run_pixel(24'h444444, 4'd3, 0);
    chk("re_ep1", epoch, 1);

    // Reset mid-SCAN.
    dist_max();
    pix_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("scan_busy", {busy, pix_ready}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_strobes", {S_wr, op_wr, USS_ctrl, done, pix_ready}, 0);
    chk("mrst_epoch", epoch, 0);
    chk("mrst_win", winner, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_stay", busy, 0);
    pulse_start();
    dist_winner9(); run_pixel(24'h555555, 4'd9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
